seq_divider: RTL and testbench

Parametrised multi-cycle integer divider with its own control FSM and datapath. It generalises the fixed 32-bit unsigned shift/subtract divider to any `WIDTH` and adds signed mode, divide-by-zero handling and a start/ready handshake. It sits beside the ALU as the long-latency divide unit, issued by the core's execute-stage control.

---
 rtl/seq_divider.sv | 145 ++++++++++++++
 tb/tb_seq_divider.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider, unsigned or two's-complement.
// One quotient bit per cycle, followed by a sign-fixup cycle that publishes the result.
`timescale 1ns/1ps
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Ready,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  state_t           state_r, state_next_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH:0]   r_r;          // partial remainder, one extra bit so MSB-set divisors cannot overflow
  logic [WIDTH-1:0] q_r;          // quotient shift register; holds the raw dividend in the zero case
  logic [WIDTH-1:0] d_r;          // divisor magnitude
  logic             qneg_r, rneg_r, zero_r;
  logic             accept_s, iter_s, fix_s;
  logic             dvd_neg_s, dvs_neg_s, dvs_zero_s;
  logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s;
  logic [WIDTH:0]   r_shift_s, trial_s;
  logic [WIDTH-1:0] q_shift_s;

  // Two's-complement negate when neg is set; the most-negative value maps onto itself.
  function automatic logic [WIDTH-1:0] negate_if(input logic neg, input logic [WIDTH-1:0] v);
    negate_if = neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic: a zero divisor skips the iterations entirely.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) state_next_s = dvs_zero_s ? FIX : ITER;
        else       state_next_s = IDLE;
      end
      ITER: begin
        if (count_r == LAST_C) state_next_s = FIX;
        else                   state_next_s = ITER;
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    accept_s = 1'b0;
    iter_s   = 1'b0;
    fix_s    = 1'b0;
    case (state_r)
      IDLE:    accept_s = Start;
      ITER:    iter_s   = 1'b1;
      FIX:     fix_s    = 1'b1;
      default: accept_s = 1'b0;
    endcase
  end

  // Operand sign detection and magnitude conversion at issue time.
  always_comb begin
    dvd_neg_s  = Signed & Dividend[WIDTH-1];
    dvs_neg_s  = Signed & Divisor[WIDTH-1];
    dvd_mag_s  = negate_if(dvd_neg_s, Dividend);
    dvs_mag_s  = negate_if(dvs_neg_s, Divisor);
    dvs_zero_s = (Divisor == {WIDTH{1'b0}});
  end

  // One restoring step: shift {R,Q} left and trial-subtract the divisor.
  always_comb begin
    r_shift_s = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
    q_shift_s = {q_r[WIDTH-2:0], 1'b0};
    trial_s   = r_shift_s - {1'b0, d_r};
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count_r   <= {CW{1'b0}};
      r_r       <= {(WIDTH+1){1'b0}};
      q_r       <= {WIDTH{1'b0}};
      d_r       <= {WIDTH{1'b0}};
      qneg_r    <= 1'b0;
      rneg_r    <= 1'b0;
      zero_r    <= 1'b0;
      Quotient  <= {WIDTH{1'b0}};
      Remainder <= {WIDTH{1'b0}};
      Busy      <= 1'b0;
      Ready     <= 1'b0;
      DivZero   <= 1'b0;
    end else if (accept_s) begin
      qneg_r  <= dvd_neg_s ^ dvs_neg_s;
      rneg_r  <= dvd_neg_s;
      zero_r  <= dvs_zero_s;
      d_r     <= dvs_mag_s;
      r_r     <= {(WIDTH+1){1'b0}};
      count_r <= {CW{1'b0}};
      q_r     <= dvs_zero_s ? Dividend : dvd_mag_s;
      Ready   <= 1'b0;
      DivZero <= 1'b0;
      Busy    <= 1'b1;
    end else if (iter_s) begin
      count_r <= count_r + ONE_C;
      if (!trial_s[WIDTH]) begin
        r_r <= trial_s;
        q_r <= {q_shift_s[WIDTH-1:1], 1'b1};
      end else begin
        r_r <= r_shift_s;
        q_r <= q_shift_s;
      end
    end else if (fix_s) begin
      if (zero_r) begin
        Quotient  <= {WIDTH{1'b1}};
        Remainder <= q_r;
        DivZero   <= 1'b1;
      end else begin
        Quotient  <= negate_if(qneg_r, q_r);
        Remainder <= negate_if(rneg_r, r_r[WIDTH-1:0]);
        DivZero   <= 1'b0;
      end
      Ready <= 1'b1;
      Busy  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of a 32-bit divider plus a corner/sweep run on an 8-bit one.
`timescale 1ns/1ps
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst32, start32, sgn32;
  logic [31:0] dvd32, dvs32, q32, r32;
  logic        busy32, rdy32, dz32;
  logic        rst8, start8, sgn8;
  logic [7:0]  dvd8, dvs8, q8, r8;
  logic        busy8, rdy8, dz8;
  int          total = 0;
  int          bad = 0;

  seq_divider #(.WIDTH(32)) u_div32 (
    .clk(clk), .Reset(rst32), .Start(start32), .Signed(sgn32),
    .Dividend(dvd32), .Divisor(dvs32), .Quotient(q32), .Remainder(r32),
    .Busy(busy32), .Ready(rdy32), .DivZero(dz32));

  seq_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .Reset(rst8), .Start(start8), .Signed(sgn8),
    .Dividend(dvd8), .Divisor(dvs8), .Quotient(q8), .Remainder(r8),
    .Busy(busy8), .Ready(rdy8), .DivZero(dz8));

  always #5 clk = ~clk;

  // Present an operation so it is accepted on the next rising edge.
  task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b, input logic hold);
    @(negedge clk);
    start32 = 1'b1; sgn32 = s; dvd32 = a; dvs32 = b;
    @(posedge clk); #1;
    if (!hold) start32 = 1'b0;
  endtask

  // Count edges until Ready; optionally poke a bogus Start at edge count 'poke'.
  task automatic wait32(input int poke, output int lat, output int bc, output int both);
    lat = 0; bc = busy32 ? 1 : 0; both = 0;
    while (!rdy32 && lat < 200) begin
      if (poke >= 0 && lat == poke) begin
        start32 = 1'b1; sgn32 = 1'b1; dvd32 = 32'hDEAD_BEEF; dvs32 = 32'h0000_0003;
      end else if (poke >= 0 && lat == poke + 1) begin
        start32 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (busy32) bc++;
      if (busy32 && rdy32) both++;
    end
    if (poke >= 0) start32 = 1'b0;
  endtask

  task automatic test_reset;
    rst32 = 1'b1; rst8 = 1'b1; start32 = 1'b0; start8 = 1'b0;
    sgn32 = 1'b0; sgn8 = 1'b0; dvd32 = 32'd0; dvs32 = 32'd0; dvd8 = 8'd0; dvs8 = 8'd0;
    #12;
    total++;
    if ({q32, r32, busy32, rdy32, dz32} !== 67'd0) begin
      bad++; $display("FAIL reset32: got q=%h r=%h b=%b rd=%b z=%b expected all zero", q32, r32, busy32, rdy32, dz32);
    end
    total++;
    if ({q8, r8, busy8, rdy8, dz8} !== 19'd0) begin
      bad++; $display("FAIL reset8: got q=%h r=%h b=%b rd=%b z=%b expected all zero", q8, r8, busy8, rdy8, dz8);
    end
    @(negedge clk); rst32 = 1'b0; rst8 = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat, bc, both;
    issue32(1'b0, 32'd100, 32'd7, 1'b0);
    wait32(-1, lat, bc, both);
    total++;
    if ({q32, r32, dz32} !== {32'd14, 32'd2, 1'b0}) begin
      bad++; $display("FAIL u100div7: got q=%h r=%h z=%b expected q=0000000e r=00000002 z=0", q32, r32, dz32);
    end
    total++;
    if (lat !== 33 || bc !== 33 || both !== 0) begin
      bad++; $display("FAIL u_latency: got lat=%0d busy=%0d both=%0d expected 33 33 0", lat, bc, both);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({q32, r32, rdy32, busy32} !== {32'd14, 32'd2, 1'b1, 1'b0}) begin
      bad++; $display("FAIL idle_hold: got q=%h r=%h rd=%b b=%b expected 0000000e 00000002 1 0", q32, r32, rdy32, busy32);
    end
    issue32(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    wait32(-1, lat, bc, both);
    total++;
    if ({q32, r32, dz32} !== {32'd1, 32'h7FFF_FFFF, 1'b0} || lat !== 33) begin
      bad++; $display("FAIL u_msb_divisor: got q=%h r=%h z=%b lat=%0d expected 00000001 7fffffff 0 33", q32, r32, dz32, lat);
    end
  endtask

  task automatic test_signed;
    logic [31:0] a_t [3];
    logic [31:0] b_t [3];
    logic [31:0] eq_t [3];
    logic [31:0] er_t [3];
    int lat, bc, both;
    a_t = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    b_t = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    eq_t = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    er_t = '{32'hFFFF_FFFF, 32'd1, 32'd0};
    for (int i = 0; i < 3; i++) begin
      issue32(1'b1, a_t[i], b_t[i], 1'b0);
      wait32(-1, lat, bc, both);
      total++;
      if ({q32, r32, dz32} !== {eq_t[i], er_t[i], 1'b0} || lat !== 33) begin
        bad++; $display("FAIL signed%0d: got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=0 lat=33", i, q32, r32, dz32, lat, eq_t[i], er_t[i]);
      end
    end
  endtask

  task automatic test_divzero;
    int lat, bc, both;
    issue32(1'b0, 32'd5, 32'd0, 1'b0);
    wait32(-1, lat, bc, both);
    total++;
    if ({q32, r32, dz32} !== {32'hFFFF_FFFF, 32'd5, 1'b1} || lat !== 1 || bc !== 1) begin
      bad++; $display("FAIL udivzero: got q=%h r=%h z=%b lat=%0d busy=%0d expected ffffffff 00000005 1 1 1", q32, r32, dz32, lat, bc);
    end
    issue32(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
    wait32(-1, lat, bc, both);
    total++;
    if ({q32, r32, dz32} !== {32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1} || lat !== 1) begin
      bad++; $display("FAIL sdivzero: got q=%h r=%h z=%b lat=%0d expected ffffffff fffffffb 1 1", q32, r32, dz32, lat);
    end
  endtask

  task automatic test_start_busy;
    int lat, bc, both;
    issue32(1'b0, 32'd100, 32'd7, 1'b0);
    total++;
    if (dz32 !== 1'b0 || rdy32 !== 1'b0) begin
      bad++; $display("FAIL accept_clears: got z=%b rd=%b expected 0 0", dz32, rdy32);
    end
    wait32(5, lat, bc, both);
    total++;
    if ({q32, r32, dz32} !== {32'd14, 32'd2, 1'b0} || lat !== 33 || both !== 0) begin
      bad++; $display("FAIL start_busy: got q=%h r=%h z=%b lat=%0d expected 0000000e 00000002 0 33", q32, r32, dz32, lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, both;
    issue32(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    rst32 = 1'b1;
    #1;
    total++;
    if ({q32, r32, busy32, rdy32, dz32} !== 67'd0) begin
      bad++; $display("FAIL reset_mid: got q=%h r=%h b=%b rd=%b z=%b expected all zero", q32, r32, busy32, rdy32, dz32);
    end
    @(posedge clk); @(negedge clk); rst32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy32, rdy32} !== 2'b00) begin
      bad++; $display("FAIL reset_idle: got b=%b rd=%b expected 0 0", busy32, rdy32);
    end
    issue32(1'b0, 32'd100, 32'd7, 1'b0);
    wait32(-1, lat, bc, both);
    total++;
    if ({q32, r32} !== {32'd14, 32'd2} || lat !== 33) begin
      bad++; $display("FAIL after_reset: got q=%h r=%h lat=%0d expected 0000000e 00000002 33", q32, r32, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc, both;
    issue32(1'b0, 32'd100, 32'd7, 1'b1);
    dvd32 = 32'hFFFF_FFFF; dvs32 = 32'h8000_0000;
    wait32(-1, lat, bc, both);
    total++;
    if ({q32, r32} !== {32'd14, 32'd2} || lat !== 33) begin
      bad++; $display("FAIL b2b_first: got q=%h r=%h lat=%0d expected 0000000e 00000002 33", q32, r32, lat);
    end
    @(posedge clk); #1;
    total++;
    if ({busy32, rdy32} !== 2'b10) begin
      bad++; $display("FAIL b2b_accept: got b=%b rd=%b expected 1 0", busy32, rdy32);
    end
    start32 = 1'b0;
    wait32(-1, lat, bc, both);
    total++;
    if ({q32, r32} !== {32'd1, 32'h7FFF_FFFF} || lat !== 33) begin
      bad++; $display("FAIL b2b_second: got q=%h r=%h lat=%0d expected 00000001 7fffffff 33", q32, r32, lat);
    end
  endtask

  // Reference result {quotient, remainder, divzero} from plain integer arithmetic.
  function automatic logic [16:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, qi, ri;
    if (b == 8'd0) return {8'hFF, a, 1'b1};
    if (s) begin
      sa = int'($signed(a)); sb = int'($signed(b));
    end else begin
      sa = int'({24'd0, a}); sb = int'({24'd0, b});
    end
    qi = sa / sb;
    ri = sa % sb;
    return {qi[7:0], ri[7:0], 1'b0};
  endfunction

  // One 8-bit operation with its own expected-value and latency check.
  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic [16:0] exp_v;
    int exp_lat;
    @(negedge clk);
    start8 = 1'b1; sgn8 = s; dvd8 = a; dvs8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!rdy8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_v = model8(s, a, b);
    exp_lat = (b == 8'd0) ? 1 : 9;
    total++;
    if ({q8, r8, dz8} !== exp_v || lat !== exp_lat) begin
      bad++; $display("FAIL w8 s=%b %h/%h: got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=%b lat=%0d",
                      s, a, b, q8, r8, dz8, lat, exp_v[16:9], exp_v[8:1], exp_v[0], exp_lat);
    end
  endtask

  task automatic test_w8_sweep;
    logic [7:0] v_t [10];
    v_t = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h64, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j < 10; j++) begin
          run8(s[0], v_t[i], v_t[j]);
        end
      end
      for (int k = 0; k < 256; k++) begin
        run8(s[0], k[7:0], 8'h03);
        run8(s[0], k[7:0], 8'hFD);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_w8_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
